// File: rtl/buf_chain_pkg.sv
// buf_chain_pkg: shared handshake type and sizing helper for elastic_buffer_chain.
package buf_chain_pkg;

    typedef struct packed {
        logic valid;
        logic ready;
    } stage_t;

    function automatic int occ_width(input int depth);
        return ($clog2(depth + 1) > 1) ? $clog2(depth + 1) : 1;
    endfunction

endpackage

// File: rtl/buffer_stage.sv
// buffer_stage: one valid/data register of the elastic chain with combinational ready passthrough.
module buffer_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign ready = !valid || down_ready;

    // Data only loads under a real incoming word, so bubbles never toggle the register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (ready)
                valid <= up_valid;
            if (!flush && ready && up_valid)
                data <= up_data;
        end
    end

endmodule

// File: rtl/elastic_buffer_chain.sv
// elastic_buffer_chain: DEPTH registered valid/ready stages of WIDTH bits with synchronous flush.
// Define BUF_CHAIN_OCCUPANCY_EN to add the registered occupancy counter port.
module elastic_buffer_chain
    import buf_chain_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data
`ifdef BUF_CHAIN_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    // Per-stage signals live in their own generate scope so the ready ripple stays acyclic.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid, down_ready, ready, valid;
        logic [WIDTH-1:0] up_data, data;
        if (i == 0) begin : g_head
            assign up_valid = in_valid && in_ready;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = g_stage[i-1].valid;
            assign up_data  = g_stage[i-1].data;
        end
        if (i == DEPTH - 1) begin : g_tail
            assign down_ready = out_ready;
        end else begin : g_link
            assign down_ready = g_stage[i+1].ready;
        end
        buffer_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .down_ready (down_ready),
            .ready      (ready),
            .valid      (valid),
            .data       (data)
        );
    end

    assign in_ready  = g_stage[0].ready && !flush;
    assign out_valid = g_stage[DEPTH-1].valid;
    assign out_data  = g_stage[DEPTH-1].data;

`ifdef BUF_CHAIN_OCCUPANCY_EN
    localparam int OW = occ_width(DEPTH);
    stage_t in_hs, out_hs;
    assign in_hs  = '{valid: in_valid, ready: in_ready};
    assign out_hs = '{valid: out_valid, ready: out_ready};

    // A take during flush is discarded along with everything else.
    always_ff @(posedge clk) begin
        if (!rst_n || flush)
            occupancy <= '0;
        else
            occupancy <= occupancy + OW'(in_hs.valid && in_hs.ready) - OW'(out_hs.valid && out_hs.ready);
    end
`endif

endmodule
